// File: rtl/sync_vata_axil_resp.sv
// sync_vata_axil_resp
//   AXI4-Lite register slave (CTRL, PERIOD, COUNT, SCRATCH) that drives a
//   registered one-cycle sync pulse for VATA distribution. COUNT runs from 0
//   up to PERIOD while enabled; the cycle after the match sync_out pulses and
//   COUNT wraps. A FORCE write fires one pulse immediately.
//   Optional build macro: SYNC_VATA_SLVERR_EN -- accesses to 0x10-0x1F answer
//   SLVERR instead of OKAY (they never read data or change state either way).
module sync_vata_axil_resp #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // write response channel
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  // sync pulse
  output logic                            sync_out
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [DW-1:0] PERIOD_RST  = DW'(32'h000F_423F);

`ifdef SYNC_VATA_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  // Word index = address bits [4:2]; indices 4..7 are the unmapped 0x10-0x1F.
  typedef enum logic [2:0] {
    IDX_CTRL    = 3'd0,
    IDX_PERIOD  = 3'd1,
    IDX_COUNT   = 3'd2,
    IDX_SCRATCH = 3'd3
  } reg_idx_e;

  // Handshake / capture state
  logic            live_q;      // low for the cycle after reset so all READYs read 0
  logic            aw_done_q;
  logic            w_done_q;
  logic [2:0]      awidx_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic            rvalid_q;
  logic [1:0]      rresp_q;
  logic [DW-1:0]   rdata_q;

  // Register file and sync generator
  logic            en_q,      en_d;
  logic [DW-1:0]   period_q,  period_d;
  logic [DW-1:0]   count_q,   count_d;
  logic [DW-1:0]   scratch_q, scratch_d;
  logic            sync_q,    sync_d;

  logic            wr_commit;
  logic            force_pulse;
  logic [DW-1:0]   rd_word;

  // PROT and the byte-offset address bits carry no meaning for this block.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Byte-lane merge of a write into an existing register value.
  function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // Both halves of a write are held; it commits on the next edge, together with BVALID.
  assign wr_commit = aw_done_q & w_done_q;

  assign S_AXI_AWREADY = live_q & ~aw_done_q & ~bvalid_q;
  assign S_AXI_WREADY  = live_q & ~w_done_q  & ~bvalid_q;
  assign S_AXI_ARREADY = live_q & ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign sync_out      = sync_q;

  // Register write decode plus COUNT/sync next state (FORCE overrides the run logic).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    en_d        = en_q;
    period_d    = period_q;
    scratch_d   = scratch_q;
    count_d     = count_q;
    sync_d      = 1'b0;
    force_pulse = 1'b0;

    if (wr_commit) begin
      case (awidx_q)
        IDX_CTRL: begin
          if (wstrb_q[0]) begin
            en_d        = wdata_q[0];
            force_pulse = wdata_q[1];
          end
        end
        IDX_PERIOD:  period_d  = merge_strb(period_q,  wdata_q, wstrb_q);
        IDX_SCRATCH: scratch_d = merge_strb(scratch_q, wdata_q, wstrb_q);
        default: ;  // COUNT is read-only; 0x10-0x1F have no storage
      endcase
    end

    if (force_pulse) begin
      count_d = '0;
      sync_d  = 1'b1;
    end else if (en_q) begin
      if (count_q == period_q) begin
        count_d = '0;
        sync_d  = 1'b1;
      end else begin
        // A PERIOD below COUNT simply lets COUNT roll over through all-ones.
        count_d = count_q + DW'(1);
      end
    end else begin
      count_d = '0;
    end
  end

  // Read mux on the live AR address; sampled at the handshake edge, so a write
  // committing on that same edge is not yet visible.
  always_comb begin
    rd_word = '0;
    case (S_AXI_ARADDR[4:2])
      IDX_CTRL:    rd_word[0] = en_q;
      IDX_PERIOD:  rd_word    = period_q;
      IDX_COUNT:   rd_word    = count_q;
      IDX_SCRATCH: rd_word    = scratch_q;
      default:     rd_word    = '0;
    endcase
  end

  // AXI channel state, registers and sync pulse; synchronous active-high reset.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    if (ARESET) begin
      live_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      en_q      <= 1'b0;
      period_q  <= PERIOD_RST;
      count_q   <= '0;
      scratch_q <= '0;
      sync_q    <= 1'b0;
    end else begin
      live_q <= 1'b1;

      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_done_q <= 1'b1;
        awidx_q   <= S_AXI_AWADDR[4:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_done_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end

      if (wr_commit) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= (SLVERR_EN && awidx_q[2]) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= (SLVERR_EN && S_AXI_ARADDR[4]) ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end

      en_q      <= en_d;
      period_q  <= period_d;
      count_q   <= count_d;
      scratch_q <= scratch_d;
      sync_q    <= sync_d;
    end
  end

endmodule

// File: tb/tb_sync_vata_axil_resp.sv
// tb_sync_vata_axil_resp
//   Table of register accesses applied in a loop, followed by hand-written
//   sequences for handshake ordering, back-pressure, the sync generator and
//   reset. Expected B/R responses are queued when a request is issued and
//   popped when the DUT answers. Inputs are driven and outputs sampled on the
//   falling clock edge.
module tb_sync_vata_axil_resp;

  localparam logic [1:0] OKAY = 2'b00;
`ifdef SYNC_VATA_SLVERR_EN
  localparam logic [1:0] EXT_RESP = 2'b10;
`else
  localparam logic [1:0] EXT_RESP = 2'b00;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [4:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        sync_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] mask;
    logic [1:0]  resp;
  } rexp_t;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;

  rexp_t      exp_r_q[$];
  logic [1:0] exp_b_q[$];
  vec_t       vecs[$];

  always #5 ACLK = ~ACLK;

  sync_vata_axil_resp #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .sync_out      (sync_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_r(input logic [4:0] addr, input logic [31:0] exp, input logic [1:0] resp);
    vec_t v;
    v = '{1'b0, addr, 32'h0, 4'h0, exp, resp};
    vecs.push_back(v);
  endtask

  task automatic add_w(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       input logic [1:0] resp);
    vec_t v;
    v = '{1'b1, addr, data, strb, 32'h0, resp};
    vecs.push_back(v);
  endtask

  // Wait for BVALID, compare against the scoreboard, complete the handshake.
  task automatic wait_b(input string name, output logic sync_at_b);
    logic       seen;
    logic [1:0] exp;
    seen      = 1'b0;
    sync_at_b = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (S_AXI_BVALID) begin
        seen      = 1'b1;
        sync_at_b = sync_out;
        exp       = (exp_b_q.size() != 0) ? exp_b_q.pop_front() : 2'bxx;
        check({name, "_bresp"}, 32'(S_AXI_BRESP), 32'(exp));
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
      end else begin
        @(negedge ACLK);
      end
    end
    check({name, "_bvalid_seen"}, 32'(seen), 32'd1);
  endtask

  // Wait for RVALID, compare against the scoreboard, complete the handshake.
  task automatic wait_r(input string name, output logic [31:0] data);
    logic  seen;
    rexp_t e;
    seen = 1'b0;
    data = '0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (S_AXI_RVALID) begin
        seen = 1'b1;
        data = S_AXI_RDATA;
        e    = (exp_r_q.size() != 0) ? exp_r_q.pop_front() : 'x;
        if (e.mask != 32'h0)
          check({name, "_rdata"}, S_AXI_RDATA & e.mask, e.data & e.mask);
        check({name, "_rresp"}, 32'(S_AXI_RRESP), 32'(e.resp));
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
      end else begin
        @(negedge ACLK);
      end
    end
    check({name, "_rvalid_seen"}, 32'(seen), 32'd1);
  endtask

  // Write with W presented w_lead cycles ahead of AW (0 = same cycle).
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp, input int w_lead, input string name,
                           output logic sync_at_b);
    logic aw_ok, w_ok, aw_hs, w_hs, early_b;
    int   cyc;
    exp_b_q.push_back(resp);
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_WVALID  = 1'b1;
    S_AXI_AWVALID = (w_lead == 0);
    aw_ok = 1'b0; w_ok = 1'b0; early_b = 1'b0; cyc = 0;
    while (!(aw_ok && w_ok) && cyc < 60) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      cyc++;
      if (aw_hs) begin aw_ok = 1'b1; S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_ok  = 1'b1; S_AXI_WVALID  = 1'b0; end
      if (!aw_ok && S_AXI_BVALID) early_b = 1'b1;
      if (!aw_ok && !S_AXI_AWVALID && cyc >= w_lead) S_AXI_AWVALID = 1'b1;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check({name, "_aw_w_accepted"}, 32'({aw_ok, w_ok}), 32'd3);
    check({name, "_no_early_b"}, 32'(early_b), 32'd0);
    wait_b(name, sync_at_b);
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp, input logic [31:0] mask,
                          input logic [1:0] resp, input string name, output logic [31:0] data);
    logic  hs;
    rexp_t e;
    e = '{data: exp, mask: mask, resp: resp};
    exp_r_q.push_back(e);
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 50 && !hs; c++) begin
      hs = S_AXI_ARREADY;
      @(negedge ACLK);
    end
    S_AXI_ARVALID = 1'b0;
    check({name, "_ar_accepted"}, 32'(hs), 32'd1);
    wait_r(name, data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s;
    logic [31:0] d;
    logic [31:0] cnt_v [3];
    logic [15:0] sv;
    int          ones, bad, bad_ar, nz;
    rexp_t       e;

    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA  = '0; S_AXI_WSTRB  = '0; S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b101; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    S_AXI_AWPROT = 3'b010;

    repeat (3) @(negedge ACLK);
    check("reset_outputs", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                                S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, sync_out}), 32'd0);
    check("reset_rdata", S_AXI_RDATA, 32'd0);
    ARESET = 1'b0;

    // Register-map vectors
    add_r(5'h00, 32'h0000_0000, OKAY);
    add_r(5'h04, 32'h000F_423F, OKAY);
    add_r(5'h08, 32'h0000_0000, OKAY);
    add_r(5'h0C, 32'h0000_0000, OKAY);
    add_r(5'h1C, 32'h0000_0000, EXT_RESP);
    add_w(5'h08, 32'h0000_1234, 4'hF, OKAY);      // COUNT is read-only
    add_r(5'h08, 32'h0000_0000, OKAY);
    add_w(5'h00, 32'hFFFF_FFF8, 4'hF, OKAY);      // upper CTRL bits ignored
    add_r(5'h00, 32'h0000_0000, OKAY);
    add_w(5'h0C, 32'hDEAD_BEEF, 4'hF, OKAY);
    add_w(5'h0C, 32'h0000_0000, 4'h5, OKAY);      // clear bytes 0 and 2
    add_r(5'h0C, 32'hDE00_BE00, OKAY);
    add_w(5'h10, 32'h1234_5678, 4'hF, EXT_RESP);
    add_r(5'h10, 32'h0000_0000, EXT_RESP);
    add_r(5'h14, 32'h0000_0000, EXT_RESP);
    add_w(5'h04, 32'h0000_0002, 4'hF, OKAY);      // PERIOD before EN so COUNT never passes it
    add_w(5'h00, 32'h0000_0001, 4'hF, OKAY);
    add_w(5'h08, 32'h0000_0003, 4'hF, OKAY);
    add_w(5'h0C, 32'h0000_0004, 4'hF, OKAY);
    add_r(5'h00, 32'h0000_0001, OKAY);
    add_r(5'h04, 32'h0000_0002, OKAY);
    add_r(5'h0C, 32'h0000_0004, OKAY);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr)
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, 0,
                  $sformatf("vec%0d", i), s);
      else
        axi_read(vecs[i].addr, vecs[i].exp, 32'hFFFF_FFFF, vecs[i].resp,
                 $sformatf("vec%0d", i), d);
    end

    // COUNT running with PERIOD=2: staggered reads must land on different phases.
    for (int k = 0; k < 3; k++) begin
      repeat (k) @(negedge ACLK);
      axi_read(5'h08, 32'h0, 32'h0, OKAY, "count_run", cnt_v[k]);
    end
    bad = 0; nz = 0;
    for (int k = 0; k < 3; k++) begin
      if (cnt_v[k] > 32'd2) bad++;
      if (cnt_v[k] != 32'd0) nz++;
    end
    check("count_in_range", 32'(bad), 32'd0);
    check("count_nonzero_seen", 32'(nz != 0), 32'd1);

    // W three cycles ahead of AW, single byte lane onto zero
    axi_write(5'h0C, 32'h0000_0000, 4'hF, OKAY, 0, "scratch_clear", s);
    axi_write(5'h0C, 32'hA5A5_A5A5, 4'h2, OKAY, 3, "w_before_aw", s);
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      if (S_AXI_BVALID) ones++;
      @(negedge ACLK);
    end
    check("single_bvalid", 32'(ones), 32'd0);
    axi_read(5'h0C, 32'h0000_A500, 32'hFFFF_FFFF, OKAY, "strb_lane1", d);

    // Read of SCRATCH on the same edge its write commits returns the old value
    exp_b_q.push_back(OKAY);
    e = '{data: 32'h0000_A500, mask: 32'hFFFF_FFFF, resp: OKAY};
    exp_r_q.push_back(e);
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h1122_3344; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    check("same_cycle_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd7);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 5'h0C; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("same_cycle_b_r_valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd3);
    wait_r("same_cycle_read", d);
    wait_b("same_cycle_write", s);
    axi_read(5'h0C, 32'h1122_3344, 32'hFFFF_FFFF, OKAY, "same_cycle_after", d);

    // PERIOD=3: one pulse every 4th cycle
    axi_write(5'h04, 32'h0000_0003, 4'hF, OKAY, 0, "period3", s);
    repeat (4) @(negedge ACLK);
    for (int i = 0; i < 16; i++) begin
      sv[i] = sync_out;
      @(negedge ACLK);
    end
    check("p3_pulse_count", 32'($countones(sv)), 32'd4);
    bad = 0;
    for (int i = 0; i < 12; i++) if (sv[i] != sv[i+4]) bad++;
    check("p3_spacing", 32'(bad), 32'd0);

    // PERIOD=0: sync held high (stop first so COUNT restarts at 0)
    axi_write(5'h00, 32'h0000_0000, 4'hF, OKAY, 0, "stop0", s);
    axi_write(5'h04, 32'h0000_0000, 4'hF, OKAY, 0, "period0", s);
    axi_write(5'h00, 32'h0000_0001, 4'hF, OKAY, 0, "run0", s);
    repeat (2) @(negedge ACLK);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (sync_out) ones++;
      @(negedge ACLK);
    end
    check("p0_always_high", 32'(ones), 32'd8);

    // EN=0: sync low, COUNT held at 0
    axi_write(5'h00, 32'h0000_0000, 4'hF, OKAY, 0, "disable", s);
    repeat (2) @(negedge ACLK);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (sync_out) ones++;
      @(negedge ACLK);
    end
    check("en0_sync_low", 32'(ones), 32'd0);
    axi_read(5'h08, 32'h0, 32'hFFFF_FFFF, OKAY, "en0_count", d);

    // FORCE with EN=0: exactly one pulse, in the cycle BVALID appears
    axi_write(5'h00, 32'h0000_0002, 4'h1, OKAY, 0, "force", s);
    check("force_pulse", 32'(s), 32'd1);
    check("force_single", 32'(sync_out), 32'd0);
    axi_read(5'h00, 32'h0, 32'hFFFF_FFFF, OKAY, "force_reads0", d);

    // Back-pressure: RREADY low for 10 cycles while a second AR waits
    axi_write(5'h04, 32'h0000_0077, 4'hF, OKAY, 0, "period77", s);
    e = '{data: 32'h0000_0077, mask: 32'hFFFF_FFFF, resp: OKAY};
    exp_r_q.push_back(e);
    S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1;
    s = 1'b0;
    for (int c = 0; c < 50 && !s; c++) begin
      s = S_AXI_ARREADY;
      @(negedge ACLK);
    end
    check("bp_ar_accepted", 32'(s), 32'd1);
    S_AXI_ARADDR = 5'h0C;
    bad = 0; bad_ar = 0;
    for (int i = 0; i < 10; i++) begin
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h0000_0077) bad++;
      if (S_AXI_ARREADY !== 1'b0) bad_ar++;
      @(negedge ACLK);
    end
    S_AXI_ARVALID = 1'b0;
    check("bp_rdata_stable", 32'(bad), 32'd0);
    check("bp_arready_low", 32'(bad_ar), 32'd0);
    wait_r("bp_read", d);
    ones = 0;
    for (int i = 0; i < 3; i++) begin
      if (S_AXI_RVALID) ones++;
      @(negedge ACLK);
    end
    check("bp_no_second_read", 32'(ones), 32'd0);

    // Reset while a write response is pending
    S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h0000_0055; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    check("rst_b_pending", 32'(S_AXI_BVALID), 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("rst_drops_b", 32'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
    ARESET = 1'b0;
    axi_read(5'h04, 32'h000F_423F, 32'hFFFF_FFFF, OKAY, "rst_period", d);
    check("scoreboard_empty", 32'(exp_r_q.size() + exp_b_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_vata_axil_resp.md
SYNC_VATA_AXIL_RESP -- requirements
Module: sync_vata_axil_resp

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (0x00-0x1F decoded).
REQ-003 The block SHALL have port ACLK, input, 1 bit: the single clock, all logic rising-edge.
REQ-004 The block SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports S_AXI_AWADDR in [ADDR_WIDTH], S_AXI_AWPROT in [3], S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-006 The block SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-007 The block SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-008 The block SHALL have ports S_AXI_ARADDR in [ADDR_WIDTH], S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-009 The block SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-010 The block SHALL have port sync_out, output, 1 bit: registered one-cycle sync pulse to VATA distribution.

Function
REQ-011 Register map SHALL be: 0x00 CTRL (bit0 EN rw, bit1 FORCE write-1-pulse reads 0, others 0); 0x04 PERIOD rw 32; 0x08 COUNT ro 32; 0x0C SCRATCH rw 32; PROT ignored.
REQ-012 AWREADY/WREADY SHALL each be high when its channel has not yet been captured and BVALID is low; AW and W SHALL be captured independently in any order or the same cycle.
REQ-013 The register write SHALL occur in the cycle after both AW and W are captured, honouring WSTRB per byte, with BVALID asserted that same cycle and BRESP=OKAY.
REQ-014 BVALID SHALL hold until the BREADY handshake; no new AW/W SHALL be accepted while BVALID is high.
REQ-015 ARREADY SHALL be high when RVALID is low; RDATA/RRESP/RVALID SHALL be registered one cycle after the AR handshake and held stable until RREADY.
REQ-016 A read and write to the same register completing in one cycle SHALL return the pre-write value.
REQ-017 Writes to COUNT SHALL be ignored with BRESP=OKAY; bits 31:2 of CTRL SHALL be ignored.
REQ-018 With EN=1 COUNT SHALL increment each cycle from 0; when COUNT==PERIOD, sync_out SHALL be 1 next cycle and COUNT SHALL wrap to 0.
REQ-019 PERIOD=0 with EN=1 SHALL hold sync_out high every cycle.
REQ-020 With EN=0 COUNT SHALL be held at 0 and sync_out at 0.
REQ-021 A FORCE write SHALL produce one sync_out pulse in the cycle after the write and reset COUNT to 0, regardless of EN.
REQ-022 A PERIOD write taking effect below current COUNT SHALL let COUNT run to 0xFFFFFFFF, wrap to 0 without pulse, then continue.

Reset
REQ-023 On ARESET=1 at a clock edge all READY, VALID, BRESP, RRESP, RDATA, sync_out SHALL be 0, CTRL/COUNT/SCRATCH 0, PERIOD 0x000F423F.
REQ-024 Reset mid-transaction SHALL drop captured AW/W and pending B/R responses without completing them.

Configuration
REQ-025 With SYNC_VATA_SLVERR_EN defined, accesses to 0x10-0x1F SHALL return SLVERR (reads RDATA=0) and not modify state; without it they SHALL return OKAY, RDATA=0, no effect.

Verification
REQ-026 Write 0x1,0x2,0x3,0x4 to 0x00-0x0C then read back -> CTRL=0x1, PERIOD=0x2, COUNT nonzero running, SCRATCH=0x4, all OKAY.
REQ-027 W presented 3 cycles before AW, SCRATCH=0xA5A5A5A5 WSTRB=0x2 onto 0 -> SCRATCH reads 0x0000A500, one BVALID.
REQ-028 PERIOD=3, EN=1 -> sync_out high every 4th cycle; PERIOD=0 -> sync_out constant 1; EN=0 -> 0.
REQ-029 RREADY held low 10 cycles after read of 0x04 -> RDATA stable, ARREADY low throughout, no second read accepted.
REQ-030 Read 0x14 -> RRESP=2 with SYNC_VATA_SLVERR_EN, 0 without; RDATA=0 both builds.
REQ-031 ARESET pulsed while BVALID pending -> BVALID 0 next cycle, PERIOD reads 0x000F423F.
